// File: rtl/bn_res_seq_ctrl.sv
// bn_res_seq_ctrl: sequencer for batch-norm + residual-add; loads per-channel BN
// parameters, then issues one datapath beat per pixel under three-way handshake.
module bn_res_seq_ctrl #(
   parameter int CHANNEL_NUM = 256,
   parameter int PIX_NUM     = 196,
   parameter int CH_AW       = $clog2(CHANNEL_NUM),
   parameter int PIX_AW      = $clog2(PIX_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              skip_load,
   input  logic              para_valid,
   output logic              para_ready,
   output logic              para_wr_en,
   output logic [CH_AW-1:0]  para_wr_addr,
   output logic              mode,
   input  logic              psum_valid,
   output logic              psum_ready,
   input  logic              res_valid,
   output logic              res_ready,
   output logic [PIX_AW-1:0] res_rd_addr,
   input  logic              out_ready,
   output logic              data_e,
   input  logic              data_e_out,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_t;
   state_t            r_state, w_next;
   logic [CH_AW-1:0]  r_ch_cnt;
   logic [PIX_AW-1:0] r_pix_cnt;
   logic              w_acc, w_fire, w_ch_last, w_pix_last;
   assign w_acc      = (r_state == LOAD) && para_valid;
   assign w_fire     = (r_state == CALC) && psum_valid && res_valid && out_ready;
   assign w_ch_last  = r_ch_cnt == CH_AW'(CHANNEL_NUM - 1);
   assign w_pix_last = r_pix_cnt == PIX_AW'(PIX_NUM - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? (skip_load ? CALC : LOAD) : IDLE;
         LOAD:    w_next = (w_acc && w_ch_last) ? CALC : LOAD;
         CALC:    w_next = (w_fire && w_pix_last) ? DRAIN : CALC;
         DRAIN:   w_next = data_e_out ? DONE : DRAIN;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ch_cnt  <= '0;
         r_pix_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) r_ch_cnt <= w_ch_last ? '0 : r_ch_cnt + CH_AW'(1);
         if (w_fire) r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + PIX_AW'(1);
      end
   end
   // the pixel counter doubles as the residual read address
   assign res_rd_addr  = r_pix_cnt;
   assign para_ready   = r_state == LOAD;
   assign para_wr_en   = w_acc;
   assign para_wr_addr = r_ch_cnt;
   assign mode         = (r_state == CALC) || (r_state == DRAIN);
   assign data_e       = w_fire;
   assign psum_ready   = w_fire;
   assign res_ready    = w_fire;
   assign busy         = r_state != IDLE;
   assign done         = r_state == DONE;
endmodule

// File: tb/tb_bn_res_seq_ctrl.sv
// tb_bn_res_seq_ctrl: scoreboard of expected write/read addresses plus a
// vector table for the CALC handshake and hand-written multi-cycle sequences.
module tb_bn_res_seq_ctrl;
   logic clk = 0, rst = 1, start = 0, skip_load = 0, para_valid = 0;
   logic psum_valid = 0, res_valid = 0, out_ready = 0, data_e_out = 0;
   logic para_ready, para_wr_en, mode, psum_ready, res_ready, data_e, busy, done;
   logic [7:0] para_wr_addr, res_rd_addr;
   int total = 0, bad = 0, nwr = 0, nbeat = 0;
   int q_ch[$], q_pix[$];

   typedef struct {logic pv, rv, orr, st, pav, e;} vec_t;
   vec_t vt[8];

   bn_res_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .skip_load(skip_load),
      .para_valid(para_valid), .para_ready(para_ready), .para_wr_en(para_wr_en),
      .para_wr_addr(para_wr_addr), .mode(mode), .psum_valid(psum_valid),
      .psum_ready(psum_ready), .res_valid(res_valid), .res_ready(res_ready),
      .res_rd_addr(res_rd_addr), .out_ready(out_ready), .data_e(data_e),
      .data_e_out(data_e_out), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (!rst) begin
      if (para_wr_en) begin
         nwr++;
         if (q_ch.size() == 0) chk("wr_unexpected", 1, 0);
         else chk("wr_addr", {mode, para_wr_addr}, {1'b0, 8'(q_ch.pop_front())});
      end
      if (data_e) begin
         nbeat++;
         if (q_pix.size() == 0) chk("beat_unexpected", 1, 0);
         else chk("beat_addr", {mode, psum_ready, res_ready, res_rd_addr},
                  {3'b111, 8'(q_pix.pop_front())});
      end
   end

   task automatic start_frame(input logic skip);
      @(posedge clk); #1;
      start = 1; skip_load = skip;
      nwr = 0; nbeat = 0;
      if (!skip) for (int i = 0; i < 256; i++) q_ch.push_back(i);
      for (int i = 0; i < 196; i++) q_pix.push_back(i);
      @(posedge clk); #1;
      start = 0; skip_load = 0;
   endtask

   // Runs CALC to completion; data_e_out mirrors data_e one cycle late like the BN stage.
   task automatic run_calc(input bit stalls, input int exp_beats, input bit consec);
      int s10 = 0, s20 = 0, n = 0, first = -1, last = -1, done_at = -1;
      bit prev_e = 0, stalled;
      logic [7:0] addr_at_done = 8'hff;
      for (int c = 0; c < 400 && done_at < 0; c++) begin
         @(posedge clk); #1;
         data_e_out = prev_e;
         psum_valid = 1; res_valid = 1; out_ready = 1; stalled = 0;
         if (stalls && mode && res_rd_addr == 10 && s10 < 3) begin out_ready = 0; s10++; stalled = 1; end
         else if (stalls && mode && res_rd_addr == 20 && s20 < 2) begin res_valid = 0; s20++; stalled = 1; end
         @(negedge clk);
         prev_e = data_e;
         if (data_e) begin n++; if (first < 0) first = c; last = c; end
         if (stalled) chk("stall_quiet", {data_e, psum_ready, res_ready}, 0);
         if (done) begin done_at = c; addr_at_done = res_rd_addr; end
      end
      chk("done_seen", done_at >= 0, 1);
      chk("beats", n, exp_beats);
      chk("done_latency", done_at - last, 2);
      chk("rd_addr_end", addr_at_done, 0);
      if (stalls) chk("stall_count", s10 + s20, 5);
      if (consec) chk("consecutive", last - first + 1, 196);
      @(posedge clk); #1;
      psum_valid = 0; res_valid = 0; out_ready = 0; data_e_out = 0;
      @(negedge clk);
      chk("idle_after_done", {mode, busy, done}, 0);
      chk("pix_queue_empty", q_pix.size(), 0);
   endtask

   initial begin
      int lc, la, viol;
      logic lw;
      logic [7:0] lad;
      vt[0] = '{0,0,0,1,1,0}; vt[1] = '{1,1,1,1,1,1}; vt[2] = '{0,1,1,0,1,0};
      vt[3] = '{1,0,1,1,0,0}; vt[4] = '{1,1,0,0,1,0}; vt[5] = '{1,1,1,1,1,1};
      vt[6] = '{0,0,1,1,1,0}; vt[7] = '{1,0,0,1,1,0};
      #2;
      chk("reset_outs", {para_ready, para_wr_en, mode, psum_ready, res_ready, data_e, busy, done, res_rd_addr}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("idle_outs", {mode, busy, para_ready}, 0);

      // Frame 1: full load with para_valid held high
      start_frame(0);
      para_valid = 1;
      lw = 0; lad = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (mode) break;
         lw = para_wr_en; lad = para_wr_addr;
      end
      chk("load_to_calc", mode, 1);
      chk("last_wr_then_calc", {lw, lad}, {1'b1, 8'd255});
      chk("wr_count", nwr, 256);
      chk("ch_queue_empty", q_ch.size(), 0);
      foreach (vt[i]) begin
         @(posedge clk); #1;
         psum_valid = vt[i].pv; res_valid = vt[i].rv; out_ready = vt[i].orr;
         start = vt[i].st; para_valid = vt[i].pav;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {data_e, psum_ready, res_ready, mode, para_ready, para_wr_en, busy},
             {vt[i].e, vt[i].e, vt[i].e, 4'b1001});
      end
      start = 0; para_valid = 0;
      run_calc(1, 194, 0);
      chk("frame1_beats", nbeat, 196);

      // Frame 2: skip_load reuses resident parameters
      start_frame(1);
      @(negedge clk);
      chk("skip_direct_calc", {mode, busy, res_rd_addr}, {2'b11, 8'd0});
      run_calc(0, 196, 1);
      chk("skip_no_wr", nwr, 0);

      // Frame 3: para_valid toggling during LOAD
      start_frame(0);
      lc = -1; la = -1; viol = 0;
      for (int c = 0; c < 600; c++) begin
         para_valid = (c % 2 == 0);
         @(negedge clk);
         if (mode) break;
         if (para_wr_en != para_valid) viol++;
         if (para_wr_en) begin lc = c; la = para_wr_addr; end
         @(posedge clk); #1;
      end
      para_valid = 0;
      chk("toggle_wr_follows_valid", viol, 0);
      chk("toggle_last_cycle", lc, 510);
      chk("toggle_last_addr", la, 255);
      chk("toggle_wr_count", nwr, 256);

      // Reset in the middle of CALC at pixel 50
      psum_valid = 1; res_valid = 1; out_ready = 1;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (res_rd_addr == 50) break;
      end
      chk("reached_pix50", {data_e, res_rd_addr}, {1'b1, 8'd50});
      #1 rst = 1;
      #1 chk("async_reset_outs", {para_ready, para_wr_en, mode, psum_ready, res_ready, data_e, busy, done, res_rd_addr}, 0);
      #1 rst = 0;
      psum_valid = 0; res_valid = 0; out_ready = 0;
      q_pix.delete();
      start_frame(1);
      @(negedge clk);
      chk("restart_addr0", {mode, res_rd_addr}, {1'b1, 8'd0});
      run_calc(0, 196, 1);
      chk("restart_no_wr", nwr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
